// File: rtl/byte_fifo_pkg.sv
// byte_fifo_pkg: shared defaults and pointer helper for byte_fifo.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default parameter values for byte_fifo
//   ptr_inc(ptr, depth)           : circular pointer increment, wraps depth-1 -> 0
package byte_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Explicit compare instead of modulo so non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO with valid/ready handshake
// and sticky overflow/underflow flags.
//   clk        : single clock, all updates on posedge
//   reset      : synchronous active-high reset (pointers, count, flags)
//   in_data    : write data
//   in_valid   : producer offers in_data
//   in_ready   : FIFO not full
//   out_data   : head-of-queue word, 0 when empty
//   out_valid  : FIFO not empty
//   out_ready  : consumer takes out_data
//   count      : words stored, 0..DEPTH
//   overflow   : sticky, in_valid seen while full
//   underflow  : sticky, out_ready seen while empty
module byte_fifo
    import byte_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Handshake decoded from registered count only: no input-to-output combinational path.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage is not reset; stale entries are never visible because out_data is gated by count.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
            end
            if (pop) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (out_ready && !out_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo: directed self-checking bench for byte_fifo at WIDTH=8, DEPTH=4.
module tb_byte_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    byte_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 8'hab, 1'b0);

        // Reset with a push offered: nothing gets stored.
        cyc();
        cyc();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);

        // Single word in and out.
        reset = 1'b0;
        drive(1'b1, 8'hab, 1'b0);
        cyc();
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'hab);
        check("single_count", 32'(count), 1);
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        check("single_pop_count", 32'(count), 0);
        check("single_pop_valid", 32'(out_valid), 0);
        check("single_pop_data", 32'(out_data), 32'h00);
        check("single_underflow", 32'(underflow), 0);

        // Fill to full, then overflow attempt.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            cyc();
        end
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_overflow_pre", 32'(overflow), 0);
        drive(1'b1, 8'h05, 1'b0);
        cyc();
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 4);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
            cyc();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        check("drain_data", 32'(out_data), 32'h00);
        check("drain_underflow", 32'(underflow), 0);

        // Simultaneous push and pop at count=2.
        drive(1'b1, 8'hbc, 1'b0);
        cyc();
        drive(1'b1, 8'hcd, 1'b0);
        cyc();
        check("sim_pre_count", 32'(count), 2);
        check("sim_pre_head", 32'(out_data), 32'hbc);
        drive(1'b1, 8'hde, 1'b1);
        cyc();
        check("sim_count", 32'(count), 2);
        check("sim_head", 32'(out_data), 32'hcd);
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        check("sim_head2", 32'(out_data), 32'hde);
        check("sim_count2", 32'(count), 1);
        cyc();
        out_ready = 1'b0;
        check("sim_empty", 32'(count), 0);

        // Reset clears the sticky overflow before the wrap test.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst2_overflow", 32'(overflow), 0);

        // Wrap-around: 0x10..0x19 through the queue, count at most 2.
        drive(1'b1, 8'h10, 1'b0);
        cyc();
        drive(1'b1, 8'h11, 1'b0);
        cyc();
        for (int i = 2; i < 10; i++) begin
            check($sformatf("wrap_head_%0d", i - 2), 32'(out_data), 32'h10 + 32'(i - 2));
            drive(1'b1, 8'(8'h10 + i), 1'b1);
            cyc();
            check($sformatf("wrap_count_%0d", i), 32'(count), 2);
        end
        drive(1'b0, 8'h00, 1'b1);
        check("wrap_head_8", 32'(out_data), 32'h18);
        cyc();
        check("wrap_head_9", 32'(out_data), 32'h19);
        cyc();
        out_ready = 1'b0;
        check("wrap_empty", 32'(count), 0);
        check("wrap_overflow", 32'(overflow), 0);
        check("wrap_underflow", 32'(underflow), 0);

        // Full with push and pop together: push blocked, pop proceeds.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(8'ha0 + i), 1'b0);
            cyc();
        end
        drive(1'b1, 8'ha5, 1'b1);
        cyc();
        check("fullpp_count", 32'(count), 3);
        check("fullpp_overflow", 32'(overflow), 1);
        check("fullpp_in_ready", 32'(in_ready), 1);
        check("fullpp_head", 32'(out_data), 32'ha2);

        // Reset mid-operation at count=3.
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst3_count", 32'(count), 0);
        check("rst3_out_valid", 32'(out_valid), 0);
        check("rst3_out_data", 32'(out_data), 32'h00);
        check("rst3_overflow", 32'(overflow), 0);
        check("rst3_underflow", 32'(underflow), 0);

        // Underflow while empty.
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        check("udf_flag", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);
        check("udf_out_valid", 32'(out_valid), 0);

        // Push while empty with out_ready high: no bypass, word is stored.
        drive(1'b1, 8'h77, 1'b1);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        check("empty_pp_count", 32'(count), 1);
        check("empty_pp_data", 32'(out_data), 32'h77);
        check("empty_pp_overflow", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
